control_pipe: RTL and testbench

CONTROL_PIPE -- requirements
Module: control_pipe

---
 rtl/control_pipe.sv | 166 ++++++++++++++++
 tb/tb_control_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Control path for a classic 5-stage pipeline: decodes the ID-stage opcode into a
// control bundle and carries it through the ID/EX, EX/MEM and MEM/WB stage registers.
module control_pipe #(
    parameter int EXT_OPS = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             ctrl_hazard,
    input  logic             flush,
    input  logic             freeze,
    output logic [1:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             mem_branch,
    output logic             mem_jump,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_reg_write,
    output logic [1:0]       wb_sel,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             ex_illegal
);

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       illegal;
    } bundle_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam bit EXT_EN = (EXT_OPS != 0);

    bundle_t    dec;
    bundle_t    id_ex;
    logic       em_reg_write;
    logic [1:0] em_wb_sel;

    // Extended opcodes fall back to illegal when the extension is disabled.
    always_comb begin
        dec = '0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
            end
            OP_LD: begin
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = 2'b01;
            end
            OP_SD: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
            end
            OP_IALU: begin
                if (EXT_EN) begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 2'b11;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_JAL: begin
                if (EXT_EN) begin
                    dec.jump      = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wb_sel    = 2'b10;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (EXT_EN) begin
                    dec.jump      = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wb_sel    = 2'b10;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_EN) begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wb_sel    = 2'b11;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Priority: rst > freeze > flush > ctrl_hazard > advance; MEM/WB advances unless frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex        <= '0;
            mem_branch   <= 1'b0;
            mem_jump     <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            em_reg_write <= 1'b0;
            em_wb_sel    <= 2'b00;
            wb_reg_write <= 1'b0;
            wb_sel       <= 2'b00;
            illegal_cnt  <= '0;
        end else if (!freeze) begin
            wb_reg_write <= em_reg_write;
            wb_sel       <= em_wb_sel;
            if (flush) begin
                id_ex        <= '0;
                mem_branch   <= 1'b0;
                mem_jump     <= 1'b0;
                mem_read     <= 1'b0;
                mem_write    <= 1'b0;
                em_reg_write <= 1'b0;
                em_wb_sel    <= 2'b00;
            end else begin
                mem_branch   <= id_ex.branch;
                mem_jump     <= id_ex.jump;
                mem_read     <= id_ex.mem_read;
                mem_write    <= id_ex.mem_write;
                em_reg_write <= id_ex.reg_write;
                em_wb_sel    <= id_ex.wb_sel;
                if (ctrl_hazard) begin
                    id_ex <= '0;
                end else begin
                    id_ex <= dec;
                    // Count only illegals actually accepted into EX; saturate at all-ones.
                    if (dec.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
                        illegal_cnt <= illegal_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign ex_alu_op   = id_ex.alu_op;
    assign ex_alu_src  = id_ex.alu_src;
    assign ex_mem_read = id_ex.mem_read;
    assign ex_illegal  = id_ex.illegal;

endmodule

// File: tb/tb_control_pipe.sv
// Directed table-driven bench for control_pipe, plus a second instance with the
// extension disabled and a 2-bit counter for illegal-decode and saturation checks.
module tb_control_pipe;

    localparam logic [6:0] R    = 7'b0110011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] SD   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] IALU = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] ILL  = 7'b1111111;

    // EX view {alu_op, alu_src, mem_read}
    localparam logic [3:0] X0 = 4'b0000, EX_R = 4'b1000, EX_LD = 4'b0011, EX_SD = 4'b0010,
                           EX_BEQ = 4'b0100, EX_JAL = 4'b0000, EX_IALU = 4'b1110,
                           EX_JALR = 4'b0010, EX_LUI = 4'b0010;
    // MEM view {branch, jump, mem_read, mem_write}
    localparam logic [3:0] M0 = 4'b0000, MEM_LD = 4'b0010, MEM_SD = 4'b0001,
                           MEM_BEQ = 4'b1000, MEM_JAL = 4'b0100, MEM_JALR = 4'b0100;
    // WB view {reg_write, wb_sel}
    localparam logic [2:0] W0 = 3'b000, WB_R = 3'b100, WB_LD = 3'b101, WB_JAL = 3'b110,
                           WB_IALU = 3'b100, WB_JALR = 3'b110, WB_LUI = 3'b111;

    typedef struct {
        logic       rst;
        logic       freeze;
        logic       flush;
        logic       hazard;
        logic [6:0] opcode;
        logic [3:0] ex;
        logic       ill;
        logic [3:0] mem;
        logic [2:0] wb;
        logic [7:0] cnt;
    } vec_t;

    logic       clk;
    logic       rst, ctrl_hazard, flush, freeze;
    logic [6:0] opcode;
    logic [1:0] ex_alu_op, wb_sel;
    logic       ex_alu_src, ex_mem_read, ex_illegal;
    logic       mem_branch, mem_jump, mem_read, mem_write, wb_reg_write;
    logic [7:0] illegal_cnt;

    logic       d0_rst, d0_hazard, d0_flush, d0_freeze;
    logic [6:0] d0_opcode;
    logic [1:0] d0_ex_alu_op, d0_wb_sel;
    logic       d0_ex_alu_src, d0_ex_mem_read, d0_ex_illegal;
    logic       d0_mem_branch, d0_mem_jump, d0_mem_read, d0_mem_write, d0_wb_reg_write;
    logic [1:0] d0_illegal_cnt;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    control_pipe #(.EXT_OPS(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .ctrl_hazard(ctrl_hazard),
        .flush(flush), .freeze(freeze),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .mem_branch(mem_branch), .mem_jump(mem_jump), .mem_read(mem_read),
        .mem_write(mem_write), .wb_reg_write(wb_reg_write), .wb_sel(wb_sel),
        .illegal_cnt(illegal_cnt), .ex_illegal(ex_illegal)
    );

    control_pipe #(.EXT_OPS(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(d0_rst), .opcode(d0_opcode), .ctrl_hazard(d0_hazard),
        .flush(d0_flush), .freeze(d0_freeze),
        .ex_alu_op(d0_ex_alu_op), .ex_alu_src(d0_ex_alu_src), .ex_mem_read(d0_ex_mem_read),
        .mem_branch(d0_mem_branch), .mem_jump(d0_mem_jump), .mem_read(d0_mem_read),
        .mem_write(d0_mem_write), .wb_reg_write(d0_wb_reg_write), .wb_sel(d0_wb_sel),
        .illegal_cnt(d0_illegal_cnt), .ex_illegal(d0_ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic fz, input logic fl, input logic hz,
                               input logic [6:0] op, input logic [3:0] ex, input logic ill,
                               input logic [3:0] mem, input logic [2:0] wb, input logic [7:0] cnt);
        vec_t t;
        t.rst = r; t.freeze = fz; t.flush = fl; t.hazard = hz; t.opcode = op;
        t.ex = ex; t.ill = ill; t.mem = mem; t.wb = wb; t.cnt = cnt;
        return t;
    endfunction

    task automatic applyStimulus(input logic r, input logic fz, input logic fl,
                                 input logic hz, input logic [6:0] op);
        rst = r; freeze = fz; flush = fl; ctrl_hazard = hz; opcode = op;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [19:0] actual,
                               input logic [19:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got ex=%b ill=%b mem=%b wb=%b cnt=%0d, expected ex=%b ill=%b mem=%b wb=%b cnt=%0d",
                     name, actual[19:16], actual[15], actual[14:11], actual[10:8], actual[7:0],
                     expected[19:16], expected[15], expected[14:11], expected[10:8], expected[7:0]);
        end
    endtask

    task automatic stepDut0(input logic [6:0] op, input logic [3:0] ex, input logic ill,
                            input logic [1:0] cnt, input string name);
        d0_rst = 1'b0; d0_opcode = op;
        @(posedge clk);
        #1;
        checkOutput(name,
            {d0_ex_alu_op, d0_ex_alu_src, d0_ex_mem_read, d0_ex_illegal,
             d0_mem_branch, d0_mem_jump, d0_mem_read, d0_mem_write,
             d0_wb_reg_write, d0_wb_sel, 6'b0, d0_illegal_cnt},
            {ex, ill, 4'b0000, 3'b000, 6'b0, cnt});
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; ctrl_hazard = 1'b0; opcode = R;
        d0_rst = 1'b1; d0_hazard = 1'b0; d0_flush = 1'b0; d0_freeze = 1'b0; d0_opcode = R;

        //               rst fz fl hz op     ex       ill mem       wb       cnt
        vecs.push_back(v(1, 0, 0, 0, R,    X0,      0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 0, R,    EX_R,    0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 0, LD,   EX_LD,   0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 0, SD,   EX_SD,   0, MEM_LD,   WB_R,    0));
        vecs.push_back(v(0, 0, 0, 0, BEQ,  EX_BEQ,  0, MEM_SD,   WB_LD,   0));
        vecs.push_back(v(0, 0, 0, 0, JAL,  EX_JAL,  0, MEM_BEQ,  W0,      0));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, MEM_JAL,  W0,      0));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       WB_JAL,  0));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       W0,      0));
        // load-use bubble
        vecs.push_back(v(0, 0, 0, 0, LD,   EX_LD,   0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, MEM_LD,   W0,      0));
        vecs.push_back(v(0, 0, 0, 0, R,    EX_R,    0, M0,       WB_LD,   0));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       WB_R,    0));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       W0,      0));
        // flush with a jump in MEM: younger bundles squashed, jump still writes back
        vecs.push_back(v(0, 0, 0, 0, JAL,  EX_JAL,  0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 0, LD,   EX_LD,   0, MEM_JAL,  W0,      0));
        vecs.push_back(v(0, 0, 1, 0, SD,   X0,      0, M0,       WB_JAL,  0));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       W0,      0));
        // freeze overrides flush
        vecs.push_back(v(0, 0, 0, 0, R,    EX_R,    0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 0, LD,   EX_LD,   0, M0,       W0,      0));
        vecs.push_back(v(0, 1, 1, 0, SD,   EX_LD,   0, M0,       W0,      0));
        vecs.push_back(v(0, 1, 0, 0, SD,   EX_LD,   0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 0, SD,   EX_SD,   0, MEM_LD,   WB_R,    0));
        // extended ops and illegal counting
        vecs.push_back(v(0, 0, 0, 0, IALU, EX_IALU, 0, MEM_SD,   WB_LD,   0));
        vecs.push_back(v(0, 0, 0, 0, ILL,  X0,      1, M0,       W0,      1));
        vecs.push_back(v(0, 1, 0, 0, ILL,  X0,      1, M0,       W0,      1));
        vecs.push_back(v(0, 0, 0, 1, ILL,  X0,      0, M0,       WB_IALU, 1));
        vecs.push_back(v(0, 0, 1, 0, ILL,  X0,      0, M0,       W0,      1));
        vecs.push_back(v(0, 0, 0, 0, JALR, EX_JALR, 0, M0,       W0,      1));
        vecs.push_back(v(0, 0, 0, 0, LUI,  EX_LUI,  0, MEM_JALR, W0,      1));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       WB_JALR, 1));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       WB_LUI,  1));
        vecs.push_back(v(0, 0, 0, 1, R,    X0,      0, M0,       W0,      1));
        // reset with three instructions in flight, under freeze and flush
        vecs.push_back(v(0, 0, 0, 0, R,    EX_R,    0, M0,       W0,      1));
        vecs.push_back(v(0, 0, 0, 0, LD,   EX_LD,   0, M0,       W0,      1));
        vecs.push_back(v(0, 0, 0, 0, SD,   EX_SD,   0, MEM_LD,   WB_R,    1));
        vecs.push_back(v(1, 1, 1, 0, BEQ,  X0,      0, M0,       W0,      0));
        vecs.push_back(v(0, 0, 0, 0, BEQ,  EX_BEQ,  0, M0,       W0,      0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].freeze, vecs[i].flush, vecs[i].hazard,
                          vecs[i].opcode);
            checkOutput($sformatf("vec%0d", i),
                {ex_alu_op, ex_alu_src, ex_mem_read, ex_illegal,
                 mem_branch, mem_jump, mem_read, mem_write,
                 wb_reg_write, wb_sel, illegal_cnt},
                {vecs[i].ex, vecs[i].ill, vecs[i].mem, vecs[i].wb, vecs[i].cnt});
        end

        // EXT_OPS=0 treats I-ALU as illegal; 2-bit counter saturates at 3
        @(posedge clk);
        #1;
        checkOutput("d0_reset",
            {d0_ex_alu_op, d0_ex_alu_src, d0_ex_mem_read, d0_ex_illegal,
             d0_mem_branch, d0_mem_jump, d0_mem_read, d0_mem_write,
             d0_wb_reg_write, d0_wb_sel, 6'b0, d0_illegal_cnt}, 20'b0);
        stepDut0(IALU, 4'b0000, 1'b1, 2'd1, "d0_ialu_illegal1");
        stepDut0(JAL,  4'b0000, 1'b1, 2'd2, "d0_jal_illegal2");
        stepDut0(IALU, 4'b0000, 1'b1, 2'd3, "d0_illegal3");
        stepDut0(IALU, 4'b0000, 1'b1, 2'd3, "d0_sat4");
        stepDut0(IALU, 4'b0000, 1'b1, 2'd3, "d0_sat5");
        stepDut0(LD,   4'b0011, 1'b0, 2'd3, "d0_ld_legal");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
